// File: rtl/pipeline_dbg_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_dbg_pkg
//   Shared definitions for the MIPS pipeline debug path.
//   - Capture state encoding (IDLE/CAPTURE/POST/DONE), as plain 2-bit constants
//     so older tools and hand-written decoders can use the same values.
//   - Capture mode constants (FREE/STOPFULL/TRIG); code 3 is reserved and
//     behaves like FREE.
//   - Trace entry layout {dest, data, ts} at the pipeline's default widths.
//     Parametrised blocks pack the same field order into a flat vector.
// -----------------------------------------------------------------------------
package pipeline_dbg_pkg;

   // Capture states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_POST    = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Capture modes
   localparam logic [1:0] MODE_FREE     = 2'd0;
   localparam logic [1:0] MODE_STOPFULL = 2'd1;
   localparam logic [1:0] MODE_TRIG     = 2'd2;

   // Default field widths of the pipeline debug stream
   localparam int DBG_ADDR_W = 5;
   localparam int DBG_DATA_W = 32;
   localparam int DBG_TS_W   = 16;

   // One captured writeback, most significant field first
   typedef struct packed {
      logic [DBG_ADDR_W-1:0] dest;
      logic [DBG_DATA_W-1:0] data;
      logic [DBG_TS_W-1:0]   ts;
   } wb_trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
//   DEPTH x WIDTH storage for the writeback trace buffer.
//   One synchronous write port, one asynchronous (combinational) read port.
//   The array has no reset: contents are only meaningful for slots that the
//   buffer's pointers/count mark as valid.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from the array)
// -----------------------------------------------------------------------------
module trace_ram #(
   parameter int WIDTH = 53,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
//   Captures non-$zero register writebacks from the pipeline debug stream,
//   each tagged with a timestamp, into a circular buffer. Supports free-run
//   (wrap), stop-on-full and trigger + post-count capture, then drains the
//   captured entries oldest-first over a valid/ready port once capture is done.
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   wb_regwrite/dest/data    writeback debug stream
//   mode, trig_dest,
//   post_count               capture configuration, latched on arm
//   arm, stop                single-cycle control pulses (arm wins over stop)
//   rd_valid/ready,
//   rd_dest/data/ts          readout port (fields are 0 while rd_valid=0)
//   state                    capture state (IDLE/CAPTURE/POST/DONE)
//   count                    number of stored entries
//   overflow                 sticky: an entry was overwritten since arm
// -----------------------------------------------------------------------------
module wb_trace_buffer
   import pipeline_dbg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_regwrite,
   input  logic [ADDR_W-1:0]        wb_dest,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic [1:0]               mode,
   input  logic                     arm,
   input  logic                     stop,
   input  logic [ADDR_W-1:0]        trig_dest,
   input  logic [$clog2(DEPTH):0]   post_count,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [ADDR_W-1:0]        rd_dest,
   output logic [DATA_W-1:0]        rd_data,
   output logic [TS_W-1:0]          rd_ts,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + DATA_W + TS_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // ---------------------------------------------------------------- state
   logic [1:0]        state_q,      state_d;
   logic [PW-1:0]     wr_ptr_q,     wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q,     rd_ptr_d;
   logic [CW-1:0]     count_q,      count_d;
   logic              overflow_q,   overflow_d;
   logic [TS_W-1:0]   ts_q,         ts_d;
   logic [1:0]        mode_q,       mode_d;
   logic [ADDR_W-1:0] trig_dest_q,  trig_dest_d;
   logic [CW-1:0]     post_count_q, post_count_d;
   logic [CW-1:0]     remaining_q,  remaining_d;

   // ---------------------------------------------------------------- decode
   logic          capturing;
   logic          cap_event;
   logic          full;
   logic          wr_en;
   logic          rd_fire;
   logic          is_stopfull;
   logic          is_trig;
   logic [EW-1:0] ram_wdata;
   logic [EW-1:0] ram_rdata;

   assign capturing   = (state_q == ST_CAPTURE) || (state_q == ST_POST);
   assign is_stopfull = (mode_q == MODE_STOPFULL);
   assign is_trig     = (mode_q == MODE_TRIG);
   assign full        = (count_q == FULL_CNT);

   // Events coinciding with arm belong to neither the old nor the new trace.
   assign cap_event   = capturing && !arm && wb_regwrite && (wb_dest != '0);

   // STOPFULL keeps the first DEPTH entries; the other modes overwrite.
   assign wr_en       = cap_event && !(full && is_stopfull);

   assign rd_valid    = (state_q == ST_DONE) && (count_q != '0);
   assign rd_fire     = rd_valid && rd_ready;

   assign ram_wdata   = {wb_dest, wb_data, ts_q};

   // ---------------------------------------------------------------- storage
   trace_ram #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_trace_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (ram_wdata),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      ts_d         = ts_q + TS_W'(1);
      mode_d       = mode_q;
      trig_dest_d  = trig_dest_q;
      post_count_d = post_count_q;
      remaining_d  = remaining_q;

      if (arm) begin
         state_d      = ST_CAPTURE;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         overflow_d   = 1'b0;
         ts_d         = '0;
         mode_d       = mode;
         trig_dest_d  = trig_dest;
         post_count_d = post_count;
         remaining_d  = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (full) begin
               // Oldest entry is overwritten: read side skips past it.
               rd_ptr_d   = rd_ptr_q + PW'(1);
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + CW'(1);
            end
         end

         // Readout only happens in DONE, where no capture can occur.
         if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
         end

         case (state_q)
            ST_CAPTURE: begin
               if (stop) begin
                  state_d = ST_DONE;
               end else if (is_stopfull && wr_en && (count_q == FULL_CNT - CW'(1))) begin
                  // This write fills the buffer.
                  state_d = ST_DONE;
               end else if (is_trig && wr_en && (wb_dest == trig_dest_q)) begin
                  // Trigger entry itself is captured; post_count more follow.
                  if (post_count_q == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d     = ST_POST;
                     remaining_d = post_count_q;
                  end
               end
            end
            ST_POST: begin
               if (wr_en) begin
                  remaining_d = remaining_q - CW'(1);
               end
               if (stop) begin
                  state_d = ST_DONE;
               end else if (wr_en && (remaining_q == CW'(1))) begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               // IDLE and DONE only leave on arm.
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         ts_q         <= '0;
         mode_q       <= MODE_FREE;
         trig_dest_q  <= '0;
         post_count_q <= '0;
         remaining_q  <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         ts_q         <= ts_d;
         mode_q       <= mode_d;
         trig_dest_q  <= trig_dest_d;
         post_count_q <= post_count_d;
         remaining_q  <= remaining_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   // Fields are forced to zero whenever no entry is being offered.
   assign rd_dest  = rd_valid ? ram_rdata[EW-1 -: ADDR_W]      : '0;
   assign rd_data  = rd_valid ? ram_rdata[TS_W +: DATA_W]      : '0;
   assign rd_ts    = rd_valid ? ram_rdata[TS_W-1:0]            : '0;
   assign state    = state_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_buffer
//   Directed bench for wb_trace_buffer (default parameters: DEPTH=16).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   at the same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_wb_trace_buffer;
   import pipeline_dbg_pkg::*;

   logic        clk;
   logic        reset;
   logic        wb_regwrite;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic [1:0]  mode;
   logic        arm;
   logic        stop;
   logic [4:0]  trig_dest;
   logic [4:0]  post_count;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  rd_dest;
   logic [31:0] rd_data;
   logic [15:0] rd_ts;
   logic [1:0]  state;
   logic [4:0]  count;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   wb_trace_buffer dut (
      .clk         (clk),
      .reset       (reset),
      .wb_regwrite (wb_regwrite),
      .wb_dest     (wb_dest),
      .wb_data     (wb_data),
      .mode        (mode),
      .arm         (arm),
      .stop        (stop),
      .trig_dest   (trig_dest),
      .post_count  (post_count),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_dest     (rd_dest),
      .rd_data     (rd_data),
      .rd_ts       (rd_ts),
      .state       (state),
      .count       (count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [1:0] m, input logic [4:0] td, input logic [4:0] pc);
      mode = m; trig_dest = td; post_count = pc; arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
      checks++; if ({rd_dest, rd_data, rd_ts} !== 53'd0) begin errors++; $display("FAIL reset_rd_fields: got %h want 0", {rd_dest, rd_data, rd_ts}); end
      $display("test_reset: state=%0d count=%0d", state, count);
   endtask

   // ------------------------------------------------------------------
   task automatic test_free();
      do_arm(MODE_FREE, 5'd0, 5'd0);
      for (int i = 1; i <= 20; i++) begin
         wb_regwrite = 1'b1; wb_dest = 5'(i); wb_data = 32'(i);
         tick();
      end
      wb_regwrite = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (state !== ST_DONE) begin errors++; $display("FAIL free_state: got %0d want %0d", state, ST_DONE); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL free_count: got %0d want 16", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL free_overflow: got %0b want 1", overflow); end
      rd_ready = 1'b1;
      for (int i = 5; i <= 20; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_dest !== 5'(i) || rd_data !== 32'(i) || rd_ts !== 16'(i - 1)) begin
            errors++;
            $display("FAIL free_read: got v=%0b d=%0d data=%0d ts=%0d want v=1 d=%0d data=%0d ts=%0d",
                     rd_valid, rd_dest, rd_data, rd_ts, i, i, i - 1);
         end
         $display("free read: dest=%0d data=%0d ts=%0d", rd_dest, rd_data, rd_ts);
         tick();
      end
      rd_ready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || count !== 5'd0 || state !== ST_DONE) begin errors++; $display("FAIL free_drained: got v=%0b count=%0d state=%0d want v=0 count=0 state=3", rd_valid, count, state); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_stopfull();
      do_arm(MODE_STOPFULL, 5'd0, 5'd0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stopfull_arm_clears_ovf: got %0b want 0", overflow); end
      for (int i = 1; i <= 20; i++) begin
         wb_regwrite = 1'b1; wb_dest = 5'(i); wb_data = 32'(100 + i);
         tick();
         if (i == 15) begin
            checks++; if (state !== ST_CAPTURE) begin errors++; $display("FAIL stopfull_state_15: got %0d want %0d", state, ST_CAPTURE); end
         end
         if (i == 16) begin
            checks++; if (state !== ST_DONE || count !== 5'd16) begin errors++; $display("FAIL stopfull_done_16: got state=%0d count=%0d want state=3 count=16", state, count); end
         end
      end
      wb_regwrite = 1'b0;
      checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL stopfull_final: got count=%0d ovf=%0b want count=16 ovf=0", count, overflow); end
      rd_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_dest !== 5'(i) || rd_data !== 32'(100 + i) || rd_ts !== 16'(i - 1)) begin
            errors++;
            $display("FAIL stopfull_read: got v=%0b d=%0d data=%0d ts=%0d want v=1 d=%0d data=%0d ts=%0d",
                     rd_valid, rd_dest, rd_data, rd_ts, i, 100 + i, i - 1);
         end
         $display("stopfull read: dest=%0d data=%0d ts=%0d", rd_dest, rd_data, rd_ts);
         tick();
      end
      rd_ready = 1'b0;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL stopfull_drained: got v=%0b want 0", rd_valid); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_trig();
      logic [4:0] wd [7] = '{5'd3, 5'd4, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
      logic [1:0] ws [7] = '{ST_CAPTURE, ST_CAPTURE, ST_POST, ST_POST, ST_POST, ST_DONE, ST_DONE};
      do_arm(MODE_TRIG, 5'd7, 5'd3);
      for (int i = 0; i < 7; i++) begin
         wb_regwrite = 1'b1; wb_dest = wd[i]; wb_data = {27'd0, wd[i]} << 4;
         tick();
         checks++; if (state !== ws[i]) begin errors++; $display("FAIL trig_state: after r%0d got %0d want %0d", wd[i], state, ws[i]); end
      end
      wb_regwrite = 1'b0;
      checks++; if (count !== 5'd6) begin errors++; $display("FAIL trig_count: got %0d want 6", count); end
      rd_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_dest !== wd[i] || rd_data !== ({27'd0, wd[i]} << 4) || rd_ts !== 16'(i)) begin
            errors++;
            $display("FAIL trig_read: got v=%0b d=%0d data=%0d ts=%0d want v=1 d=%0d ts=%0d",
                     rd_valid, rd_dest, rd_data, rd_ts, wd[i], i);
         end
         $display("trig read: dest=%0d data=%0d ts=%0d", rd_dest, rd_data, rd_ts);
         tick();
      end
      rd_ready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || state !== ST_DONE) begin errors++; $display("FAIL trig_drained: got v=%0b state=%0d want v=0 state=3", rd_valid, state); end
   endtask

   // ------------------------------------------------------------------
   // $zero writes, writes before/with arm, and timestamp gaps. Leaves three
   // entries in the buffer for the backpressure test.
   task automatic test_zero_ts();
      bit         zw [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [4:0] zd [8] = '{5'd1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd3};
      // Write while DONE: dropped
      wb_regwrite = 1'b1; wb_dest = 5'd12; wb_data = 32'hDEAD;
      tick();
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL pre_arm_write: got count=%0d want 0", count); end
      // Write in the arm cycle: dropped
      wb_dest = 5'd13;
      do_arm(MODE_FREE, 5'd0, 5'd0);
      wb_regwrite = 1'b0;
      checks++; if (count !== 5'd0 || state !== ST_CAPTURE) begin errors++; $display("FAIL arm_cycle_write: got count=%0d state=%0d want 0/1", count, state); end
      for (int c = 0; c < 8; c++) begin
         wb_regwrite = zw[c]; wb_dest = zd[c]; wb_data = 32'h100 + 32'(c);
         stop = (c == 7);
         tick();
      end
      wb_regwrite = 1'b0; stop = 1'b0;
      checks++; if (state !== ST_DONE || count !== 5'd3) begin errors++; $display("FAIL zero_ts_count: got state=%0d count=%0d want 3/3", state, count); end
      $display("zero_ts: state=%0d count=%0d", state, count);
   endtask

   // ------------------------------------------------------------------
   task automatic test_backpressure();
      wb_trace_entry_t exp_e [3];
      bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int idx = 0;
      exp_e[0] = '{dest: 5'd1, data: 32'h100, ts: 16'd0};
      exp_e[1] = '{dest: 5'd2, data: 32'h103, ts: 16'd3};
      exp_e[2] = '{dest: 5'd3, data: 32'h107, ts: 16'd7};
      for (int c = 0; c < 5; c++) begin
         rd_ready = pat[c];
         checks++;
         if (rd_valid !== 1'b1 || rd_dest !== exp_e[idx].dest || rd_data !== exp_e[idx].data || rd_ts !== exp_e[idx].ts) begin
            errors++;
            $display("FAIL bp_read: cycle %0d got v=%0b d=%0d data=%h ts=%0d want v=1 d=%0d data=%h ts=%0d",
                     c, rd_valid, rd_dest, rd_data, rd_ts, exp_e[idx].dest, exp_e[idx].data, exp_e[idx].ts);
         end
         $display("bp cycle %0d: ready=%0b dest=%0d data=%h ts=%0d", c, rd_ready, rd_dest, rd_data, rd_ts);
         tick();
         if (pat[c]) idx++;
      end
      rd_ready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || count !== 5'd0 || {rd_dest, rd_data, rd_ts} !== 53'd0) begin errors++; $display("FAIL bp_drained: got v=%0b count=%0d fields=%h want 0/0/0", rd_valid, count, {rd_dest, rd_data, rd_ts}); end
      checks++; if (state !== ST_DONE) begin errors++; $display("FAIL bp_done_persists: got %0d want %0d", state, ST_DONE); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_arm_stop();
      stop = 1'b1;
      do_arm(MODE_FREE, 5'd0, 5'd0);
      stop = 1'b0;
      checks++; if (state !== ST_CAPTURE || count !== 5'd0) begin errors++; $display("FAIL arm_stop: got state=%0d count=%0d want 1/0", state, count); end
      for (int i = 5; i <= 6; i++) begin
         wb_regwrite = 1'b1; wb_dest = 5'(i); wb_data = 32'(i);
         tick();
      end
      wb_regwrite = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (rd_valid !== 1'b1 || count !== 5'd2) begin errors++; $display("FAIL arm_stop_fill: got v=%0b count=%0d want 1/2", rd_valid, count); end
      // Re-arm during readout discards the trace
      do_arm(MODE_FREE, 5'd0, 5'd0);
      checks++; if (rd_valid !== 1'b0 || count !== 5'd0 || state !== ST_CAPTURE) begin errors++; $display("FAIL rearm_in_done: got v=%0b count=%0d state=%0d want 0/0/1", rd_valid, count, state); end
      $display("arm_stop: state=%0d count=%0d", state, count);
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_in_post();
      do_arm(MODE_TRIG, 5'd2, 5'd4);
      wb_regwrite = 1'b1; wb_dest = 5'd2; wb_data = 32'd22; tick();
      wb_dest = 5'd3; wb_data = 32'd33; tick();
      wb_regwrite = 1'b0;
      checks++; if (state !== ST_POST || count !== 5'd2) begin errors++; $display("FAIL post_before_reset: got state=%0d count=%0d want 2/2", state, count); end
      #2 reset = 1'b0;
      #1;
      checks++; if (state !== ST_IDLE || count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got state=%0d count=%0d v=%0b want 0/0/0", state, count, rd_valid); end
      $display("reset_in_post: state=%0d count=%0d", state, count);
      @(negedge clk);
      reset = 1'b1;
      tick();
      checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL post_reset_idle: got %0d want 0", state); end
   endtask

   initial begin
      reset = 1'b0; wb_regwrite = 1'b0; wb_dest = '0; wb_data = '0;
      mode = '0; arm = 1'b0; stop = 1'b0; trig_dest = '0; post_count = '0;
      rd_ready = 1'b0;
      #2;
      test_reset();
      @(negedge clk);
      reset = 1'b1;
      tick();
      test_free();
      test_stopfull();
      test_trig();
      test_zero_ts();
      test_backpressure();
      test_arm_stop();
      test_reset_in_post();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
